// File: rtl/sfifo_gen.sv
// Synchronous single-clock FIFO with registered status flags, watermark
// flags, one-cycle error pulses and optional first-word-fall-through output.
// Storage is a simple-dual-port RAM with a registered read port.

module sfifo_gen #(
    parameter int          DATA_WIDTH = 36,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          FWFT       = 0,
    parameter logic [11:0] UPAE_DBITS = 12'd10,
    parameter logic [11:0] UPAF_DBITS = 12'd10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic                  Sync_Flush,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Almost_Full,
    output logic                  Almost_Empty,
    output logic                  Full_Watermark,
    output logic                  Empty_Watermark,
    output logic                  Overrun_Error,
    output logic                  Underrun_Error,
    output logic [DEPTH_LOG2:0]   Count
);

    localparam int              DEPTH   = 2 ** DEPTH_LOG2;
    localparam int              CW      = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   DEPTH_M1 = CW'(DEPTH - 1);
    // Thresholds kept as signed ints so an oversized UPAF simply makes the
    // full watermark always true instead of wrapping.
    localparam int              FW_TH   = DEPTH - int'(UPAF_DBITS);
    localparam int              EW_TH   = int'(UPAE_DBITS);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr_nxt;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [CW-1:0]         count_nxt;
    logic signed [31:0]    count_s;

    logic push_ok;
    logic pop_ok;
    logic rd_en;
    logic bypass;

    logic full_nxt;
    logic empty_nxt;
    logic afull_nxt;
    logic aempty_nxt;
    logic fwm_nxt;
    logic ewm_nxt;

    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  byp_q;

    // Acceptance is judged against the flags as they stand this cycle.
    assign push_ok = PUSH && !Full  && !Sync_Flush && !RESET;
    assign pop_ok  = POP  && !Empty && !Sync_Flush && !RESET;

    // Next pointers and occupancy; flush returns everything to zero.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = Count;
        if (Sync_Flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push_ok) wr_ptr_nxt = wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr_nxt = rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count_nxt = Count + 1'b1;
            else if (pop_ok && !push_ok)
                count_nxt = Count - 1'b1;
        end
    end

    assign count_s = signed'(32'(count_nxt));

    // Flags are decoded from the next occupancy so they are registered
    // in step with Count.
    always_comb begin
        full_nxt   = (count_nxt == DEPTH_C);
        empty_nxt  = (count_nxt == '0);
        afull_nxt  = (count_nxt == DEPTH_M1);
        aempty_nxt = (count_nxt == CW'(1));
        fwm_nxt    = (count_s >= FW_TH);
        ewm_nxt    = (count_s <= EW_TH);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge CLK) begin
        if (RESET || Sync_Flush) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            Count           <= '0;
            Full            <= 1'b0;
            Empty           <= 1'b1;
            Almost_Full     <= 1'b0;
            Almost_Empty    <= 1'b0;
            Full_Watermark  <= 1'b0;
            Empty_Watermark <= 1'b1;
        end else begin
            wr_ptr          <= wr_ptr_nxt;
            rd_ptr          <= rd_ptr_nxt;
            Count           <= count_nxt;
            Full            <= full_nxt;
            Empty           <= empty_nxt;
            Almost_Full     <= afull_nxt;
            Almost_Empty    <= aempty_nxt;
            Full_Watermark  <= fwm_nxt;
            Empty_Watermark <= ewm_nxt;
        end
    end

    // Error pulses: one cycle after a rejected request, suppressed by flush.
    always_ff @(posedge CLK) begin
        if (RESET || Sync_Flush) begin
            Overrun_Error  <= 1'b0;
            Underrun_Error <= 1'b0;
        end else begin
            Overrun_Error  <= PUSH && Full;
            Underrun_Error <= POP && Empty;
        end
    end

    // RAM write port.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= DIN;
    end

    // Read-port steering. Standard mode reads only on an accepted pop.
    // FWFT mode prefetches the word that will be at the head after this
    // edge; when that word is being written this same cycle the RAM would
    // return stale data, so DIN is captured instead and selected on DOUT.
    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_addr = rd_ptr_nxt;
            assign rd_en   = !Sync_Flush;
            assign bypass  = push_ok && (wr_ptr == rd_ptr_nxt);
        end else begin : g_std
            assign rd_addr = rd_ptr;
            assign rd_en   = pop_ok;
            assign bypass  = 1'b0;
        end
    endgenerate

    // Registered RAM read; holds while not enabled (flush keeps DOUT).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ram_q <= '0;
        end else if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Write-to-head forwarding register used only in FWFT mode.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            byp_q <= 1'b0;
            din_q <= '0;
        end else if (rd_en) begin
            byp_q <= bypass;
            if (bypass) din_q <= DIN;
        end
    end

    assign DOUT = byp_q ? din_q : ram_q;

endmodule

// File: tb/tb_sfifo_gen.sv
// Self-checking bench for sfifo_gen: a standard-mode instance (depth 16,
// watermarks 3/3) and an FWFT instance, each checked against a queue model.

module tb_sfifo_gen;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic [DW-1:0] din0 = '0, dout0;
    logic          push0 = 0, pop0 = 0, flush0 = 0;
    logic          full0, empty0, af0, ae0, fwm0, ewm0, ovr0, und0;
    logic [4:0]    cnt0;

    logic [DW-1:0] din1 = '0, dout1;
    logic          push1 = 0, pop1 = 0, flush1 = 0;
    logic          full1, empty1, af1, ae1, fwm1, ewm1, ovr1, und1;
    logic [4:0]    cnt1;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] exp_dout0 = '0;
    logic          exp_ovr0 = 0, exp_und0 = 0;
    logic          exp_ovr1 = 0, exp_und1 = 0;

    sfifo_gen #(.DATA_WIDTH(DW), .DEPTH_LOG2(4), .FWFT(0),
                .UPAE_DBITS(12'd3), .UPAF_DBITS(12'd3)) dut (
        .CLK(clk), .RESET(rst), .DIN(din0), .PUSH(push0), .POP(pop0),
        .Sync_Flush(flush0), .DOUT(dout0), .Full(full0), .Empty(empty0),
        .Almost_Full(af0), .Almost_Empty(ae0), .Full_Watermark(fwm0),
        .Empty_Watermark(ewm0), .Overrun_Error(ovr0), .Underrun_Error(und0),
        .Count(cnt0));

    sfifo_gen #(.DATA_WIDTH(DW), .DEPTH_LOG2(4), .FWFT(1),
                .UPAE_DBITS(12'd3), .UPAF_DBITS(12'd3)) dut_fw (
        .CLK(clk), .RESET(rst), .DIN(din1), .PUSH(push1), .POP(pop1),
        .Sync_Flush(flush1), .DOUT(dout1), .Full(full1), .Empty(empty1),
        .Almost_Full(af1), .Almost_Empty(ae1), .Full_Watermark(fwm1),
        .Empty_Watermark(ewm1), .Overrun_Error(ovr1), .Underrun_Error(und1),
        .Count(cnt1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout sim did not finish");
        $fatal(1, "timeout");
    end

    // One clock on the standard instance; model updates after the edge.
    task automatic cyc0(input bit pu, input bit po, input bit fl, input logic [DW-1:0] d);
        bit ap, aq;
        push0 = pu; pop0 = po; flush0 = fl; din0 = d;
        ap = pu && !fl && (q0.size() < 16);
        aq = po && !fl && (q0.size() > 0);
        exp_ovr0 = pu && !fl && !ap;
        exp_und0 = po && !fl && !aq;
        @(posedge clk); #1;
        if (fl) q0.delete();
        else begin
            if (aq) exp_dout0 = q0.pop_front();
            if (ap) q0.push_back(d);
        end
        push0 = 0; pop0 = 0; flush0 = 0;
    endtask

    // One clock on the FWFT instance.
    task automatic cyc1(input bit pu, input bit po, input logic [DW-1:0] d);
        bit ap, aq;
        push1 = pu; pop1 = po; din1 = d;
        ap = pu && (q1.size() < 16);
        aq = po && (q1.size() > 0);
        exp_ovr1 = pu && !ap;
        exp_und1 = po && !aq;
        @(posedge clk); #1;
        if (aq) void'(q1.pop_front());
        if (ap) q1.push_back(d);
        push1 = 0; pop1 = 0;
    endtask

    task automatic test_reset;
        rst = 1; push0 = 1; pop0 = 1; flush0 = 1; din0 = 8'h77;
        push1 = 1; din1 = 8'h99;
        repeat (2) @(posedge clk);
        #1;
        q0.delete(); q1.delete(); exp_dout0 = '0;
        checks++;
        if (cnt0 !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
        checks++;
        if ({full0, empty0, af0, ae0, fwm0, ewm0} !== 6'b010001) begin
            failures++; $display("FAIL reset_flags got=%b exp=010001", {full0, empty0, af0, ae0, fwm0, ewm0});
        end
        checks++;
        if ({ovr0, und0} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {ovr0, und0}); end
        checks++;
        if (dout0 !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout0); end
        checks++;
        if ({cnt1, empty1, dout1} !== {5'd0, 1'b1, 8'h00}) begin
            failures++; $display("FAIL reset_fwft got=%0d/%b/%h exp=0/1/00", cnt1, empty1, dout1);
        end
        rst = 0; push0 = 0; pop0 = 0; flush0 = 0; push1 = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill;
        int c;
        logic [5:0] ef;
        for (int i = 0; i < 16; i++) begin
            cyc0(1, 0, 0, DW'(i));
            c  = q0.size();
            ef = {c == 16, c == 0, c == 15, c == 1, c >= 13, c <= 3};
            checks++;
            if (cnt0 !== 5'(c)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", cnt0, c); end
            checks++;
            if ({full0, empty0, af0, ae0, fwm0, ewm0} !== ef) begin
                failures++; $display("FAIL fill_flags cnt=%0d got=%b exp=%b", c, {full0, empty0, af0, ae0, fwm0, ewm0}, ef);
            end
            checks++;
            if (ovr0 !== 1'b0) begin failures++; $display("FAIL fill_ovr got=%b exp=0", ovr0); end
        end
        cyc0(1, 0, 0, 8'hFF);
        checks++;
        if ({ovr0, cnt0, full0} !== {exp_ovr0, 5'd16, 1'b1}) begin
            failures++; $display("FAIL overrun got=%b/%0d/%b exp=%b/16/1", ovr0, cnt0, full0, exp_ovr0);
        end
        cyc0(0, 0, 0, 8'h00);
        checks++;
        if (ovr0 !== 1'b0) begin failures++; $display("FAIL overrun_once got=%b exp=0", ovr0); end
    endtask

    task automatic test_drain;
        int c;
        logic [5:0] ef;
        for (int i = 0; i < 16; i++) begin
            cyc0(0, 1, 0, 8'h00);
            c  = q0.size();
            ef = {c == 16, c == 0, c == 15, c == 1, c >= 13, c <= 3};
            checks++;
            if (dout0 !== exp_dout0) begin failures++; $display("FAIL drain_data got=%h exp=%h", dout0, exp_dout0); end
            checks++;
            if ({full0, empty0, af0, ae0, fwm0, ewm0} !== ef || cnt0 !== 5'(c)) begin
                failures++; $display("FAIL drain_flags cnt=%0d got=%b/%0d exp=%b", c, {full0, empty0, af0, ae0, fwm0, ewm0}, cnt0, ef);
            end
        end
        cyc0(0, 1, 0, 8'h00);
        checks++;
        if ({und0, empty0, cnt0} !== {exp_und0, 1'b1, 5'd0}) begin
            failures++; $display("FAIL underrun got=%b/%b/%0d exp=%b/1/0", und0, empty0, cnt0, exp_und0);
        end
        cyc0(0, 0, 0, 8'h00);
        checks++;
        if (und0 !== 1'b0 || dout0 !== exp_dout0) begin
            failures++; $display("FAIL underrun_once got=%b/%h exp=0/%h", und0, dout0, exp_dout0);
        end
    endtask

    task automatic test_simultaneous_reject;
        cyc0(1, 1, 0, 8'h21);
        checks++;
        if ({und0, ovr0, cnt0} !== {exp_und0, exp_ovr0, 5'(q0.size())}) begin
            failures++; $display("FAIL empty_pushpop got=%b/%b/%0d exp=%b/%b/%0d", und0, ovr0, cnt0, exp_und0, exp_ovr0, q0.size());
        end
        for (int i = 0; i < 15; i++) cyc0(1, 0, 0, DW'(8'h30 + i));
        cyc0(1, 1, 0, 8'hEE);
        checks++;
        if ({ovr0, und0, cnt0} !== {exp_ovr0, exp_und0, 5'(q0.size())}) begin
            failures++; $display("FAIL full_pushpop got=%b/%b/%0d exp=%b/%b/%0d", ovr0, und0, cnt0, exp_ovr0, exp_und0, q0.size());
        end
        checks++;
        if (dout0 !== exp_dout0) begin failures++; $display("FAIL full_pushpop_data got=%h exp=%h", dout0, exp_dout0); end
        for (int i = 0; i < 7; i++) begin
            cyc0(0, 1, 0, 8'h00);
            checks++;
            if (dout0 !== exp_dout0) begin failures++; $display("FAIL trim_data got=%h exp=%h", dout0, exp_dout0); end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 40; i++) begin
            cyc0(1, 1, 0, DW'(100 + i));
            checks++;
            if (cnt0 !== 5'd8 || cnt0 !== 5'(q0.size())) begin
                failures++; $display("FAIL b2b_count got=%0d exp=8", cnt0);
            end
            checks++;
            if (dout0 !== exp_dout0) begin failures++; $display("FAIL b2b_data got=%h exp=%h", dout0, exp_dout0); end
            checks++;
            if ({ovr0, und0} !== 2'b00) begin failures++; $display("FAIL b2b_err got=%b exp=00", {ovr0, und0}); end
        end
        for (int i = 0; i < 3; i++) begin
            cyc0(0, 1, 0, 8'h00);
            checks++;
            if (dout0 !== exp_dout0) begin failures++; $display("FAIL b2b_tail got=%h exp=%h", dout0, exp_dout0); end
        end
    endtask

    task automatic test_flush;
        checks++;
        if (cnt0 !== 5'd5) begin failures++; $display("FAIL preflush_count got=%0d exp=5", cnt0); end
        cyc0(1, 0, 1, 8'hEE);
        checks++;
        if ({cnt0, full0, empty0, af0, ae0, fwm0, ewm0} !== {5'd0, 6'b010001}) begin
            failures++; $display("FAIL flush_state got=%0d/%b exp=0/010001", cnt0, {full0, empty0, af0, ae0, fwm0, ewm0});
        end
        checks++;
        if (dout0 !== exp_dout0 || {ovr0, und0} !== 2'b00) begin
            failures++; $display("FAIL flush_hold got=%h/%b exp=%h/00", dout0, {ovr0, und0}, exp_dout0);
        end
        cyc0(1, 0, 0, 8'h5B);
        cyc0(0, 1, 0, 8'h00);
        checks++;
        if (dout0 !== exp_dout0 || empty0 !== 1'b1) begin
            failures++; $display("FAIL postflush_first got=%h/%b exp=%h/1", dout0, empty0, exp_dout0);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) cyc0(1, 0, 0, DW'(8'hC0 + i));
        rst = 1; push0 = 1; din0 = 8'hDD;
        @(posedge clk); #1;
        rst = 0; push0 = 0;
        q0.delete(); exp_dout0 = '0;
        checks++;
        if ({cnt0, empty0, dout0} !== {5'd0, 1'b1, 8'h00}) begin
            failures++; $display("FAIL midreset got=%0d/%b/%h exp=0/1/00", cnt0, empty0, dout0);
        end
        cyc0(1, 0, 0, 8'h42);
        cyc0(0, 1, 0, 8'h00);
        checks++;
        if (dout0 !== exp_dout0 || empty0 !== 1'b1) begin
            failures++; $display("FAIL midreset_first got=%h/%b exp=%h/1", dout0, empty0, exp_dout0);
        end
    endtask

    task automatic test_fwft;
        cyc1(1, 0, 8'hA5);
        checks++;
        if ({empty1, dout1, cnt1} !== {1'b0, 8'hA5, 5'd1}) begin
            failures++; $display("FAIL fwft_first got=%b/%h/%0d exp=0/a5/1", empty1, dout1, cnt1);
        end
        cyc1(1, 0, 8'h5A);
        cyc1(1, 0, 8'h3C);
        checks++;
        if (dout1 !== q1[0]) begin failures++; $display("FAIL fwft_hold got=%h exp=%h", dout1, q1[0]); end
        cyc1(0, 1, 8'h00);
        checks++;
        if (dout1 !== q1[0]) begin failures++; $display("FAIL fwft_advance got=%h exp=%h", dout1, q1[0]); end
        for (int i = 0; i < 60; i++) begin
            cyc1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
            checks++;
            if (cnt1 !== 5'(q1.size()) || empty1 !== (q1.size() == 0) || {ovr1, und1} !== {exp_ovr1, exp_und1}) begin
                failures++; $display("FAIL fwft_state got=%0d/%b/%b exp=%0d/%b/%b", cnt1, empty1, {ovr1, und1}, q1.size(), q1.size() == 0, {exp_ovr1, exp_und1});
            end
            if (q1.size() > 0) begin
                checks++;
                if (dout1 !== q1[0]) begin failures++; $display("FAIL fwft_head got=%h exp=%h", dout1, q1[0]); end
            end
        end
        while (q1.size() > 1) cyc1(0, 1, 8'h00);
        cyc1(1, 1, 8'h6E);
        checks++;
        if ({empty1, dout1} !== {1'b0, 8'h6E}) begin
            failures++; $display("FAIL fwft_bypass got=%b/%h exp=0/6e", empty1, dout1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous_reject();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_fwft();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
